vga_scanout: RTL and testbench

Parametrised VGA timing generator and framebuffer scan-out engine driven by `clk25`. It produces hsync/vsync and a 4:4:4 colour stream, and fetches a windowed source image from a synchronous framebuffer RAM of configurable read latency. It supports integer pixel replication (1x/2x/4x) and a border colour outside the window. It sits between the camera/processing framebuffer and the board VGA pins.

---
 rtl/vga_pkg.sv | 49 ++++
 rtl/vga_timing.sv | 54 +++++
 rtl/vga_scanout.sv | 144 ++++++++++++++
 tb/tb_vga_scanout.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA scan-out slice.
//   - default 640x480@60 timing and window parameters
//   - rgb444_t colour struct and RGB565 -> RGB444 conversion
//   - pipe_flags_t, the per-pixel flag bundle carried down the delay line
//   - pipe_lat(): counter-to-pin latency for a given framebuffer read latency
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int WIN_X_DEF = 160;
  localparam int WIN_Y_DEF = 120;
  localparam int WIN_W_DEF = 320;
  localparam int WIN_H_DEF = 240;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef struct packed {
    logic active;
    logic win;
    logic hs;
    logic vs;
  } pipe_flags_t;

  // Keep the top bits of each RGB565 channel (green drops its two LSBs).
  function automatic rgb444_t rgb565_to_444(input logic [15:0] p);
    rgb444_t c;
    c.r = p[15:12];
    c.g = p[10:7];
    c.b = p[4:1];
    return c;
  endfunction

  // counter stage + address register + RAM latency + colour register
  function automatic int pipe_lat(input int rd_lat);
    return rd_lat + 2;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing: free-running horizontal/vertical counters and raw timing flags.
// Ports:
//   clk25, rst         pixel clock, async active-high reset
//   h_cnt, v_cnt       raw counters (stage 0)
//   active             h_cnt < H_ACTIVE and v_cnt < V_ACTIVE
//   hs_act, vs_act     sync interval flags (polarity applied downstream)
//   frame_end          combinational pulse on the last pixel of the frame
module vga_timing import vga_pkg::*; #(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic       clk25,
  input  logic       rst,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       active,
  output logic       hs_act,
  output logic       vs_act,
  output logic       frame_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  assign active    = (h_cnt < 10'(H_ACTIVE)) && (v_cnt < 10'(V_ACTIVE));
  assign hs_act    = (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign vs_act    = (v_cnt >= VS_START) && (v_cnt < VS_END);
  assign frame_end = !rst && (h_cnt == H_LAST) && (v_cnt == V_LAST);

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: VGA timing plus windowed framebuffer scan-out with integer
// pixel replication and a border colour around the window.
// Ports:
//   clk25, rst                   pixel clock, async active-high reset
//   frame_addr                   registered framebuffer read address
//   frame_pixel                  RGB565 read data, RD_LAT cycles after address
//   vga_red/green/blue           registered RGB444 colour
//   vga_hsync, vga_vsync         registered syncs, aligned with colour
//   h_cnt, v_cnt                 raw counters (not pipeline-aligned)
//   frame_end                    pulse on the last counter position of a frame
module vga_scanout import vga_pkg::*; #(
  parameter int          H_ACTIVE   = H_ACTIVE_DEF,
  parameter int          H_FP       = H_FP_DEF,
  parameter int          H_SYNC     = H_SYNC_DEF,
  parameter int          H_BP       = H_BP_DEF,
  parameter int          V_ACTIVE   = V_ACTIVE_DEF,
  parameter int          V_FP       = V_FP_DEF,
  parameter int          V_SYNC     = V_SYNC_DEF,
  parameter int          V_BP       = V_BP_DEF,
  parameter int          WIN_X      = WIN_X_DEF,
  parameter int          WIN_Y      = WIN_Y_DEF,
  parameter int          WIN_W      = WIN_W_DEF,
  parameter int          WIN_H      = WIN_H_DEF,
  parameter int          SCALE_LOG2 = 0,
  parameter int          ADDR_W     = 17,
  parameter int          RD_LAT     = 1,
  parameter bit          HS_POL     = 1'b0,
  parameter bit          VS_POL     = 1'b0,
  parameter logic [11:0] BORDER     = 12'h000
) (
  input  logic              clk25,
  input  logic              rst,
  output logic [ADDR_W-1:0] frame_addr,
  input  logic [15:0]       frame_pixel,
  output logic [3:0]        vga_red,
  output logic [3:0]        vga_green,
  output logic [3:0]        vga_blue,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic [9:0]        h_cnt,
  output logic [9:0]        v_cnt,
  output logic              frame_end
);

  localparam int LAT = pipe_lat(RD_LAT);
  localparam int SW  = WIN_W >> SCALE_LOG2;
  localparam int SH  = WIN_H >> SCALE_LOG2;
  localparam logic [ADDR_W-1:0] SW_A  = ADDR_W'(SW);
  localparam logic [9:0]        SMASK = 10'((1 << SCALE_LOG2) - 1);

  if (SCALE_LOG2 < 0 || SCALE_LOG2 > 2) begin : g_bad_scale
    $fatal(1, "vga_scanout: SCALE_LOG2 must be 0, 1 or 2");
  end
  if (WIN_X + WIN_W > H_ACTIVE || WIN_Y + WIN_H > V_ACTIVE) begin : g_bad_win
    $fatal(1, "vga_scanout: window exceeds active area");
  end
  if ((WIN_W % (1 << SCALE_LOG2)) != 0 || (WIN_H % (1 << SCALE_LOG2)) != 0) begin : g_bad_div
    $fatal(1, "vga_scanout: window size not divisible by scale");
  end
  if (longint'(SW) * longint'(SH) > (longint'(1) << ADDR_W)) begin : g_bad_addr
    $fatal(1, "vga_scanout: source image does not fit ADDR_W");
  end
  if (RD_LAT < 1) begin : g_bad_lat
    $fatal(1, "vga_scanout: RD_LAT must be at least 1");
  end

  logic active, hs_act, vs_act;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk25    (clk25),
    .rst      (rst),
    .h_cnt    (h_cnt),
    .v_cnt    (v_cnt),
    .active   (active),
    .hs_act   (hs_act),
    .vs_act   (vs_act),
    .frame_end(frame_end)
  );

  // Window / address generation (stage 0 -> stage 1)
  logic              in_win, win_first, line_last;
  logic [9:0]        h_off, v_off, col;
  logic [ADDR_W-1:0] line_base, base_eff;

  assign in_win = (h_cnt >= 10'(WIN_X)) && (h_cnt < 10'(WIN_X + WIN_W)) &&
                  (v_cnt >= 10'(WIN_Y)) && (v_cnt < 10'(WIN_Y + WIN_H));
  assign h_off  = h_cnt - 10'(WIN_X);
  assign v_off  = v_cnt - 10'(WIN_Y);
  assign col    = h_off >> SCALE_LOG2;

  assign win_first = (h_cnt == 10'(WIN_X)) && (v_cnt == 10'(WIN_Y));
  // Advance to the next source row only after the last replicated screen line.
  assign line_last = in_win && (h_cnt == 10'(WIN_X + WIN_W - 1)) &&
                     ((v_off & SMASK) == SMASK);
  // The base restart takes effect on the first window pixel itself.
  assign base_eff  = win_first ? '0 : line_base;

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      line_base  <= '0;
      frame_addr <= '0;
    end else begin
      if (in_win) frame_addr <= base_eff + ADDR_W'(col);
      if (line_last)      line_base <= base_eff + SW_A;
      else if (win_first) line_base <= '0;
    end
  end

  // Flag delay line: dly[k] holds the flags of the counter value k+1 cycles ago.
  pipe_flags_t dly [LAT-1];
  pipe_flags_t f_out;
  rgb444_t     pix;

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT - 1; i++) dly[i] <= '0;
    end else begin
      dly[0] <= '{active: active, win: in_win, hs: hs_act, vs: vs_act};
      for (int i = 1; i < LAT - 1; i++) dly[i] <= dly[i-1];
    end
  end

  // dly[RD_LAT] lines up with frame_pixel for the same counter value.
  assign f_out = dly[RD_LAT];
  assign pix   = rgb565_to_444(frame_pixel);

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      {vga_red, vga_green, vga_blue} <= 12'h000;
      vga_hsync <= ~HS_POL;
      vga_vsync <= ~VS_POL;
    end else begin
      vga_hsync <= f_out.hs ? HS_POL : ~HS_POL;
      vga_vsync <= f_out.vs ? VS_POL : ~VS_POL;
      if (!f_out.active)   {vga_red, vga_green, vga_blue} <= 12'h000;
      else if (!f_out.win) {vga_red, vga_green, vga_blue} <= BORDER;
      else                 {vga_red, vga_green, vga_blue} <= pix;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: directed checks on two scaled-down vga_scanout instances.
// Small timing (24x17 totals, window 8x8 at (4,3)) keeps frames at 408 cycles.
//   dut_a: SCALE_LOG2=0, RD_LAT=1 (L=3)
//   dut_b: SCALE_LOG2=1, RD_LAT=3 (L=5)
module tb_vga_scanout;

  logic clk25 = 1'b0;
  logic rst   = 1'b1;
  logic ram_mode = 1'b0;   // 0: data = address, 1: constant 16'hF800
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk25 = ~clk25;
  always @(posedge clk25) cyc <= cyc + 1;

  logic [7:0]  fa_a, fa_b;
  logic [15:0] pix_a, pb_q0, pb_q1, pb_q2;
  logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;
  logic        hs_a, vs_a, fe_a, hs_b, vs_b, fe_b;
  logic [9:0]  h_a, v_a, h_b, v_b;
  logic [11:0] col_a, col_b;

  assign col_a = {r_a, g_a, b_a};
  assign col_b = {r_b, g_b, b_b};

  always @(posedge clk25) begin
    pix_a <= ram_mode ? 16'hF800 : {8'h00, fa_a};
    pb_q0 <= ram_mode ? 16'hF800 : {8'h00, fa_b};
    pb_q1 <= pb_q0;
    pb_q2 <= pb_q1;
  end

  vga_scanout #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .WIN_X(4), .WIN_Y(3), .WIN_W(8), .WIN_H(8),
    .SCALE_LOG2(0), .ADDR_W(8), .RD_LAT(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .BORDER(12'h0F0)
  ) dut_a (
    .clk25(clk25), .rst(rst), .frame_addr(fa_a), .frame_pixel(pix_a),
    .vga_red(r_a), .vga_green(g_a), .vga_blue(b_a),
    .vga_hsync(hs_a), .vga_vsync(vs_a),
    .h_cnt(h_a), .v_cnt(v_a), .frame_end(fe_a)
  );

  vga_scanout #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .WIN_X(4), .WIN_Y(3), .WIN_W(8), .WIN_H(8),
    .SCALE_LOG2(1), .ADDR_W(8), .RD_LAT(3),
    .HS_POL(1'b0), .VS_POL(1'b0), .BORDER(12'h0F0)
  ) dut_b (
    .clk25(clk25), .rst(rst), .frame_addr(fa_b), .frame_pixel(pb_q2),
    .vga_red(r_b), .vga_green(g_b), .vga_blue(b_b),
    .vga_hsync(hs_b), .vga_vsync(vs_b),
    .h_cnt(h_b), .v_cnt(v_b), .frame_end(fe_b)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic skip(input int n);
    repeat (n) @(negedge clk25);
  endtask

  task automatic wait_hv(input int h, input int v);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk25);
      if (h_a == 10'(h) && v_a == 10'(v)) return;
    end
    check_val("wait_hv_timeout", 0, 1);
  endtask

  function automatic logic sel_sig(input int w);
    case (w)
      0:       return hs_a;
      1:       return hs_b;
      2:       return vs_a;
      default: return ~fe_a;
    endcase
  endfunction

  task automatic wait_fall(input int w, output int h_at, output int c_at);
    logic prev;
    prev = sel_sig(w);
    h_at = -1;
    c_at = -1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk25);
      if (prev && !sel_sig(w)) begin
        h_at = int'(h_a);
        c_at = cyc;
        return;
      end
      prev = sel_sig(w);
    end
    check_val("fall_timeout", 0, 1);
  endtask

  task automatic count_low(input int w, output int n);
    n = 0;
    while (!sel_sig(w) && n < 1000) begin
      n++;
      @(negedge clk25);
    end
  endtask

  int h1, c1, h2, c2, n;

  initial begin
    // reset state
    skip(3);
    check_val("rst_h_cnt", h_a, 0);
    check_val("rst_v_cnt", v_a, 0);
    check_val("rst_addr_a", fa_a, 0);
    check_val("rst_col_a", col_a, 12'h000);
    check_val("rst_hsync_a", hs_a, 1);
    check_val("rst_vsync_b", vs_b, 1);
    check_val("rst_frame_end", fe_a, 0);

    rst = 1'b0;
    #1 check_val("rel_h_cnt", h_a, 0);
    skip(2);
    check_val("blank_col_a_h2", col_a, 12'h000);
    skip(1);
    check_val("border_col_a_h3", col_a, 12'h0F0);

    // horizontal sync
    wait_fall(0, h1, c1);
    check_val("hs_fall_h_a", h1, 21);
    count_low(0, n);
    check_val("hs_low_len", n, 3);
    wait_fall(0, h2, c2);
    check_val("hs_period", c2 - c1, 24);
    wait_fall(1, h1, c1);
    check_val("hs_fall_h_b", h1, 23);

    // vertical sync and frame_end
    wait_fall(2, h1, c1);
    check_val("vs_fall_h", h1, 3);
    check_val("vs_fall_v", v_a, 13);
    count_low(2, n);
    check_val("vs_low_len", n, 48);
    wait_fall(2, h2, c2);
    check_val("vs_period", c2 - c1, 408);
    wait_fall(3, h1, c1);
    check_val("fe_h", h1, 23);
    check_val("fe_v", v_a, 16);
    skip(1);
    check_val("fe_one_cycle", fe_a, 0);
    wait_fall(3, h2, c2);
    check_val("fe_period", c2 - c1, 408);

    // colour mapping with a red framebuffer
    ram_mode = 1'b1;
    wait_hv(4, 3);
    n = 0;
    while (col_a != 12'hF00 && n < 20) begin n++; @(negedge clk25); end
    check_val("first_red_lat_a", n, 3);
    wait_hv(6, 5); skip(3);
    check_val("win_col_a", col_a, 12'hF00);
    skip(2);
    check_val("win_col_b", col_b, 12'hF00);
    wait_hv(14, 5); skip(3);
    check_val("border_col_a", col_a, 12'h0F0);
    wait_hv(20, 5);
    check_val("align_b_col20", col_b, 12'h0F0);
    check_val("align_b_hs20", hs_b, 1);
    skip(1);
    check_val("align_b_col21", col_b, 12'h000);
    check_val("hblank_col_a", col_a, 12'h000);
    skip(1);
    check_val("align_b_hs22", hs_b, 1);
    skip(1);
    check_val("align_b_hs23", hs_b, 0);
    wait_hv(5, 14); skip(3);
    check_val("vblank_col_a", col_a, 12'h000);
    wait_hv(4, 3);
    n = 0;
    while (col_b != 12'hF00 && n < 20) begin n++; @(negedge clk25); end
    check_val("first_red_lat_b", n, 5);

    // addressing with data = address
    ram_mode = 1'b0;
    wait_hv(4, 3); skip(1);
    check_val("addr_a_4_3", fa_a, 0);
    check_val("addr_b_4_3", fa_b, 0);
    wait_hv(6, 3); skip(1);
    check_val("addr_a_6_3", fa_a, 2);
    check_val("addr_b_6_3", fa_b, 1);
    wait_hv(11, 3); skip(1);
    check_val("addr_a_11_3", fa_a, 7);
    check_val("addr_b_11_3", fa_b, 3);
    wait_hv(12, 3); skip(1);
    check_val("addr_a_hold", fa_a, 7);
    check_val("addr_b_hold", fa_b, 3);
    wait_hv(4, 4); skip(1);
    check_val("addr_a_4_4", fa_a, 8);
    check_val("addr_b_4_4", fa_b, 0);
    wait_hv(5, 4); skip(1);
    check_val("addr_b_5_4", fa_b, 0);
    wait_hv(4, 5); skip(1);
    check_val("addr_a_4_5", fa_a, 16);
    check_val("addr_b_4_5", fa_b, 4);
    wait_hv(11, 10); skip(1);
    check_val("addr_a_last", fa_a, 63);
    check_val("addr_b_last", fa_b, 15);
    skip(2);
    check_val("data_col_a_last", col_a, 12'h00F);
    skip(2);
    check_val("data_col_b_last", col_b, 12'h007);

    // mid-frame asynchronous reset
    wait_hv(22, 7);
    check_val("pre_rst_hs_a", hs_a, 0);
    check_val("pre_rst_addr_a", fa_a, 39);
    #2 rst = 1'b1;
    #1;
    check_val("arst_h_cnt", h_a, 0);
    check_val("arst_v_cnt", v_a, 0);
    check_val("arst_addr_a", fa_a, 0);
    check_val("arst_addr_b", fa_b, 0);
    check_val("arst_hs_a", hs_a, 1);
    check_val("arst_vs_a", vs_a, 1);
    check_val("arst_col_b", col_b, 12'h000);
    check_val("arst_fe", fe_a, 0);
    skip(3);
    rst = 1'b0;
    #1;
    check_val("rel2_h_cnt", h_a, 0);
    check_val("rel2_v_cnt", v_a, 0);
    skip(4);
    check_val("rel2_blank_b_h4", col_b, 12'h000);
    skip(1);
    check_val("rel2_border_b_h5", col_b, 12'h0F0);
    wait_hv(4, 3); skip(1);
    check_val("rel2_addr_a", fa_a, 0);
    check_val("rel2_addr_b", fa_b, 0);
    wait_hv(4, 4); skip(1);
    check_val("rel2_addr_a_4_4", fa_a, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
